// File: rtl/rx78_ram_save_if.sv
// Host-side ioctl upload bus plus the ext RAM port-B read bus used by the
// RAM save block. The slave modport is the save block; the master modport is
// the HPS/RAM side.
interface rx78_ram_save_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic              ioctl_upload_req;
  logic [7:0]        ioctl_din;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_q;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_q,
    output ioctl_upload_req, ioctl_din, mem_addr, mem_rd
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_q,
    input  ioctl_upload_req, ioctl_din, mem_addr, mem_rd
  );
endinterface

// File: rtl/rx78_ram_save.sv
// Streams the ext RAM back to the HPS as an ioctl upload so battery/ext RAM
// can be saved. Tracks CPU writes, auto-requests an upload after the RAM has
// been dirty and quiet for HOLDOFF cycles, or on an explicit save command.
// Reads go through the RAM's second port with a 2-clk strobe-to-data latency.
module rx78_ram_save #(
  parameter int unsigned ADDR_W     = 15,
  parameter logic [7:0]  SAVE_INDEX = 8'd2,
  parameter logic [23:0] HOLDOFF    = 24'd4_000_000,
  parameter logic [23:0] REQ_TMO    = 24'd12_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_wr,
  input  logic                  save_cmd,
  rx78_ram_save_if.slave        bus,
  output logic                  dirty,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_e;

  state_e            state_q, state_d;
  logic              match, match_q, match_rise, match_fall;
  logic              dirty_q, dirty_d;
  logic [23:0]       quiet_q, quiet_d, quiet_inc;
  logic [23:0]       tmo_q, tmo_d, tmo_inc;
  logic              req_q, req_d;
  logic              rd_ok, rd_oob;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              oob1_q, oob1_d;
  logic              rd2_q, rd2_d;
  logic              oob2_q, oob2_d;
  logic [7:0]        din_q, din_d;

  assign match      = bus.ioctl_upload & (bus.ioctl_index == SAVE_INDEX);
  assign match_rise = match & ~match_q;
  assign match_fall = ~match & match_q;

  // Quiet/timeout counters, FSM next state and dirty tracking.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_d   = state_q;
    tmo_d     = tmo_q;
    req_d     = 1'b0;
    quiet_inc = (quiet_q >= HOLDOFF) ? HOLDOFF : quiet_q + 24'd1;
    tmo_inc   = (tmo_q == 24'hFF_FFFF) ? tmo_q : tmo_q + 24'd1;

    // The quiet count is settled before the FSM looks at it so a write in
    // the same cycle as the hold-off expiry postpones the request.
    quiet_d = quiet_q;
    if (dirty_q && state_q == IDLE) quiet_d = quiet_inc;
    if (cpu_wr)                     quiet_d = 24'd0;

    case (state_q)
      IDLE: begin
        if (match_rise) begin
          state_d = XFER;
        end else if (save_cmd ||
                     (dirty_q && HOLDOFF != 24'd0 && quiet_d == HOLDOFF)) begin
          state_d = REQ;
          req_d   = 1'b1;
          tmo_d   = 24'd0;
        end
      end
      REQ: begin
        tmo_d = tmo_inc;
        if (match) begin
          state_d = XFER;
        end else if (match_fall) begin
          state_d = IDLE;
        end else if (tmo_inc >= REQ_TMO) begin
          state_d = IDLE;
          quiet_d = 24'd0;
        end
      end
      XFER:    if (match_fall) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Entering DONE clears dirty, but a write in that same cycle keeps it.
    dirty_d = cpu_wr | (dirty_q & (state_d != DONE));
  end

  // Read pipeline: strobe -> port-B address/read -> RAM data -> ioctl_din.
  // It accepts a new strobe every cycle, so a strobe arriving while an
  // earlier read is still in flight is serviced right behind it.
  always_comb begin
    rd_ok      = (state_q == XFER) & bus.ioctl_rd;
    rd_oob     = |bus.ioctl_addr[24:ADDR_W];
    mem_addr_d = mem_addr_q;
    if (rd_ok && !rd_oob) mem_addr_d = bus.ioctl_addr[ADDR_W-1:0];
    mem_rd_d   = rd_ok & ~rd_oob;
    oob1_d     = rd_ok & rd_oob;
    rd2_d      = mem_rd_q;
    oob2_d     = oob1_q;
    din_d      = din_q;
    if (rd2_q)       din_d = bus.mem_q;
    else if (oob2_q) din_d = 8'hFF;
  end

  // State register; reset aborts any transfer and drops all outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      match_q    <= 1'b0;
      dirty_q    <= 1'b0;
      quiet_q    <= 24'd0;
      tmo_q      <= 24'd0;
      req_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      oob1_q     <= 1'b0;
      rd2_q      <= 1'b0;
      oob2_q     <= 1'b0;
      din_q      <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // values computed from the previous state, independent of order.
      state_q    <= state_d;
      match_q    <= match;
      dirty_q    <= dirty_d;
      quiet_q    <= quiet_d;
      tmo_q      <= tmo_d;
      req_q      <= req_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      oob1_q     <= oob1_d;
      rd2_q      <= rd2_d;
      oob2_q     <= oob2_d;
      din_q      <= din_d;
    end
  end

  assign bus.ioctl_upload_req = req_q;
  assign bus.ioctl_din        = din_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_rd           = mem_rd_q;
  assign dirty                = dirty_q;
  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);

endmodule

// File: tb/tb_rx78_ram_save.sv
// Directed bench for rx78_ram_save: auto hold-off request, request timeout,
// upload reads (in range and out of range), dirty/done interaction with CPU
// writes, and asynchronous reset in the middle of a transfer.
module tb_rx78_ram_save;

  localparam int unsigned ADDR_W = 15;

  logic clk = 1'b0;
  logic reset_n;
  logic cpu_wr;
  logic save_cmd;
  logic dirty, busy, done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] ram [0:(1<<ADDR_W)-1];

  rx78_ram_save_if #(.ADDR_W(ADDR_W)) bus ();

  rx78_ram_save #(
    .ADDR_W    (ADDR_W),
    .SAVE_INDEX(8'd2),
    .HOLDOFF   (24'd100),
    .REQ_TMO   (24'd50)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cpu_wr  (cpu_wr),
    .save_cmd(save_cmd),
    .bus     (bus),
    .dirty   (dirty),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Ext RAM port B: registered read, data one clock after mem_rd.
  always @(posedge clk) if (bus.mem_rd) bus.mem_q <= ram[bus.mem_addr];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ioctl_upload_req is seen; -1 if it never comes.
  task automatic wait_req(output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus.ioctl_upload_req === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // One host read: strobe, data checked 2 clk later, next strobe 4 clk later.
  task automatic do_read(input logic [24:0] addr, input logic [7:0] exp, input string tag);
    bus.ioctl_addr = addr;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd   = 1'b0;
    tick();
    tick();
    check(tag, {24'd0, bus.ioctl_din}, {24'd0, exp});
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   {31'd0, bus.ioctl_upload_req}, 32'd0);
    check({tag, "_din"},   {24'd0, bus.ioctl_din},        32'd0);
    check({tag, "_maddr"}, {17'd0, bus.mem_addr},         32'd0);
    check({tag, "_mrd"},   {31'd0, bus.mem_rd},           32'd0);
    check({tag, "_dirty"}, {31'd0, dirty},                32'd0);
    check({tag, "_busy"},  {31'd0, busy},                 32'd0);
    check({tag, "_done"},  {31'd0, done},                 32'd0);
  endtask

  initial begin
    int          n;
    int          seen;
    logic [24:0] a;

    for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = 8'(i) ^ 8'h5A;
    bus.mem_q        = 8'h00;
    reset_n          = 1'b0;
    cpu_wr           = 1'b0;
    save_cmd         = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index  = 8'd0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = 25'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 reset_n = 1'b1;
    tick();

    // 1: one write, request exactly HOLDOFF=100 clk later
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    check("wr_dirty", {31'd0, dirty}, 32'd1);
    check("wr_busy", {31'd0, busy}, 32'd0);
    wait_req(n);
    check("holdoff_latency", n, 32'd100);
    check("req_busy", {31'd0, busy}, 32'd1);
    check("req_dirty", {31'd0, dirty}, 32'd1);
    tick();
    check("req_one_cycle", {31'd0, bus.ioctl_upload_req}, 32'd0);

    // 4: no Match during REQ -> timeout back to IDLE, no done, dirty kept
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done === 1'b1) seen++;
      if (busy === 1'b0) break;
    end
    check("tmo_idle", {31'd0, busy}, 32'd0);
    check("tmo_no_done", seen, 32'd0);
    check("tmo_dirty", {31'd0, dirty}, 32'd1);
    wait_req(n);
    check("rereq_latency", n, 32'd100);

    // 2: Match in REQ -> XFER, stream reads
    bus.ioctl_index  = 8'd2;
    bus.ioctl_upload = 1'b1;
    tick();
    check("xfer_busy", {31'd0, busy}, 32'd1);
    check("xfer_no_req", {31'd0, bus.ioctl_upload_req}, 32'd0);
    do_read(25'h0000, 8'h5A, "rd_0000");
    do_read(25'h1234, 8'h6E, "rd_1234");
    for (int i = 1; i < 1024; i++) begin
      a = 25'(i);
      do_read(a, a[7:0] ^ 8'h5A, "rd_low");
    end
    for (int i = 16'h7FF0; i <= 16'h7FFF; i++) begin
      a = 25'(i);
      do_read(a, a[7:0] ^ 8'h5A, "rd_top");
    end
    do_read(25'h7FFF, 8'hA5, "rd_7fff");

    // 3: out-of-range read -> FF, RAM untouched, value held
    bus.ioctl_addr = 25'h8000;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd   = 1'b0;
    check("oob_mrd_1", {31'd0, bus.mem_rd}, 32'd0);
    tick();
    check("oob_mrd_2", {31'd0, bus.mem_rd}, 32'd0);
    tick();
    check("oob_din", {24'd0, bus.ioctl_din}, 32'hFF);
    repeat (3) tick();
    check("oob_hold", {24'd0, bus.ioctl_din}, 32'hFF);
    do_read(25'h0011, 8'h4B, "rd_0011");
    do_read(25'h1FF_FFFF, 8'hFF, "oob_max");

    // Match falls -> DONE pulse, dirty cleared
    bus.ioctl_upload = 1'b0;
    tick();
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_dirty", {31'd0, dirty}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("done_idle", {31'd0, busy}, 32'd0);

    // 5: save_cmd path; cpu_wr on DONE entry keeps dirty
    save_cmd = 1'b1;
    tick();
    save_cmd = 1'b0;
    check("cmd_req", {31'd0, bus.ioctl_upload_req}, 32'd1);
    check("cmd_busy", {31'd0, busy}, 32'd1);
    check("cmd_clean", {31'd0, dirty}, 32'd0);
    bus.ioctl_upload = 1'b1;
    tick();
    do_read(25'h0100, 8'h5A, "rd_0100");
    bus.ioctl_upload = 1'b0;
    cpu_wr           = 1'b1;
    tick();
    cpu_wr = 1'b0;
    check("wr_done_pulse", {31'd0, done}, 32'd1);
    check("wr_done_dirty", {31'd0, dirty}, 32'd1);
    tick();
    check("wr_done_idle", {31'd0, busy}, 32'd0);
    check("wr_done_dirty2", {31'd0, dirty}, 32'd1);

    // Write during the count restarts the hold-off
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.ioctl_upload_req === 1'b1) seen++;
    end
    check("early_no_req", seen, 32'd0);
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    wait_req(n);
    check("restart_latency", n, 32'd100);

    // 6: async reset mid-read of 0x1234
    bus.ioctl_upload = 1'b1;
    tick();
    bus.ioctl_addr = 25'h1234;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd   = 1'b0;
    check("pre_rst_mrd", {31'd0, bus.mem_rd}, 32'd1);
    check("pre_rst_maddr", {17'd0, bus.mem_addr}, 32'h1234);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    bus.ioctl_upload = 1'b0;
    tick();
    tick();
    check("rst_hold_din", {24'd0, bus.ioctl_din}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_dirty", {31'd0, dirty}, 32'd0);

    // Wrong index is ignored; right index starts a host-initiated save
    bus.ioctl_index  = 8'd3;
    bus.ioctl_upload = 1'b1;
    tick();
    tick();
    check("wrong_index", {31'd0, busy}, 32'd0);
    bus.ioctl_upload = 1'b0;
    tick();
    bus.ioctl_index  = 8'd2;
    bus.ioctl_upload = 1'b1;
    tick();
    check("host_xfer", {31'd0, busy}, 32'd1);
    check("host_no_req", {31'd0, bus.ioctl_upload_req}, 32'd0);
    do_read(25'h1234, 8'h6E, "fresh_1234");
    bus.ioctl_upload = 1'b0;
    tick();
    check("fresh_done", {31'd0, done}, 32'd1);
    tick();
    check("fresh_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
